// File: rtl/tqv_spi_host_if.sv
// Command-side bundle for the SPI host.
// The requester drives master; the host is the slave end.
interface tqv_spi_host_if;
  logic        start;
  logic        write;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;

  modport master (
    output start, write, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  start, write, addr, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/tqv_spi_host.sv
// SPI mode-0 host: serialises a 40-bit register command frame
// and captures the 32-bit read payload from miso.
module tqv_spi_host #(
  parameter int CLK_DIV = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  tqv_spi_host_if.slave bus,
  output logic          cs_n,
  output logic          sck,
  output logic          mosi,
  input  logic          miso
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [5:0]  nbit;
  logic [39:0] tx;
  logic [31:0] rx;
  logic        rd;
  logic        busy_q;
  logic        done_q;
  logic [31:0] rdata_q;
  logic        half_end;

  assign half_end  = (cnt == DIV_M1);
  // Frame MSB sits at tx[39]; it drains to zero once the frame is out.
  assign mosi      = tx[39];
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

  // Transaction sequencer: shift, hold, gap, all paced by the half-period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      nbit    <= 6'd0;
      tx      <= 40'd0;
      rx      <= 32'd0;
      rd      <= 1'b0;
      cs_n    <= 1'b1;
      sck     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      done_q <= 1'b0;
      if (state != IDLE)
        cnt <= half_end ? 8'd0 : cnt + 8'd1;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            tx     <= {bus.write, 1'b0, bus.addr,
                       bus.write ? bus.wdata : 32'h0};
            rd     <= ~bus.write;
            cs_n   <= 1'b0;
            busy_q <= 1'b1;
            cnt    <= 8'd0;
            nbit   <= 6'd0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_end) begin
            sck <= ~sck;
            if (sck) begin
              rx <= {rx[30:0], miso};
              tx <= {tx[38:0], 1'b0};
              if (nbit == 6'd39)
                state <= HOLD;
              else
                nbit <= nbit + 6'd1;
            end
          end
        end
        HOLD: begin
          if (half_end) begin
            cs_n   <= 1'b1;
            done_q <= 1'b1;
            if (rd)
              rdata_q <= rx;
            state  <= GAP;
          end
        end
        GAP: begin
          if (half_end) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tqv_spi_host.md
Name: tqv_spi_host

Overview:
- SPI host that drives transactions into the peripheral harness's SPI register interface. It is the initiator end of the link the harness responds to.
- Takes a parallel command (read or write, 6-bit register address, 32-bit data), serialises it on cs_n/sck/mosi, and captures miso read data.
- Used by the FPGA/bring-up wrapper and the cocotb bench to exercise TinyQV peripherals without a CPU.

Parameters:
- CLK_DIV, 2: clk cycles per SCK half-period. Legal range 1..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request pulse. Accepted only when busy=0.
- write  input  1  1 = write, 0 = read. Latched on accept.
- addr  input  6  register address. Latched on accept.
- wdata  input  32  write data. Latched on accept; ignored for reads.
- busy  output  1  high while a transaction or its CS-high gap is in progress.
- done  output  1  one-cycle pulse at end of transaction.
- rdata  output  32  read data. Valid from the done cycle of a read.
- cs_n  output  1  SPI chip select, active low.
- sck  output  1  SPI clock, mode 0 (idles low).
- mosi  output  1  serial data to responder.
- miso  input  1  serial data from responder.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - cs_n=1, sck=0, mosi=0, busy=0, done=0, rdata=0.
  - State returns to IDLE. No done pulse is generated for the aborted transfer.
- Frame is 40 bits, sent MSB first:
  - Header is 8 bits: {write, 1'b0, addr[5:0]}.
  - Payload is 32 bits: wdata[31:0] for writes; 32'h0 is driven on mosi for reads.
- States: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - start=1 sampled at clock edge T latches write/addr/wdata into the shift register.
  - From T+1: cs_n=0, busy=1, mosi = frame bit 39.
  - start while busy=1 is ignored, with no queuing.
- SHIFT: each bit is one SCK period of 2*CLK_DIV cycles.
  - Low half first, with mosi stable.
  - sck rises at T+1+(2k+1)*CLK_DIV and falls at T+1+(2k+2)*CLK_DIV, for bit index k=0..39.
  - mosi changes only in the cycle sck falls, or at frame start.
  - miso is sampled in the last clk cycle of each high half (just before the fall) and shifted into the read register MSB first.
  - Only the 32 samples taken during payload bits form rdata; header-phase samples are discarded.
- HOLD:
  - After the 40th falling edge, sck stays 0 and cs_n stays 0 for CLK_DIV cycles.
  - cs_n then rises at T+1+81*CLK_DIV. cs_n is low for exactly 81*CLK_DIV cycles.
- done:
  - Pulses high for exactly the one cycle in which cs_n returns to 1.
  - On a read, rdata updates in that same cycle. On a write, rdata holds its previous value.
- GAP:
  - cs_n=1, busy stays 1 for CLK_DIV more cycles, so busy is high for 82*CLK_DIV cycles total.
  - Then busy=0 and state is IDLE. start in the first cycle with busy=0 is accepted.
- mosi:
  - Returns to 0 when cs_n rises.
  - Held at 0 whenever cs_n=1.
- sck is never high while cs_n=1.
- Counters:
  - Half-period counter is 8 bits.
  - Bit counter is 6 bits and counts 40 bits, then terminates; no wrap-around into a second frame.

Test Plan:
- Reset values: hold rst_n=0 → cs_n=1, sck=0, mosi=0, busy=0, done=0, rdata=0.
- Write, CLK_DIV=2:
  - Stimulus: start with write=1, addr=6'h05, wdata=32'hDEADBEEF.
  - Bench SPI slave captures 40 bits = 40'h85DEADBEEF.
  - cs_n low 162 cycles, busy high 164 cycles, one done pulse, rdata unchanged.
- Read:
  - Stimulus: write=0, addr=6'h3F; slave returns 32'hA5A5_0F0F on payload bits.
  - Captured header is 8'h3F.
  - rdata=32'hA5A50F0F in the done cycle and held afterwards.
- Busy rejection: pulse start 10 cycles into a transaction with different addr → exactly one frame on the wire, with the first command's header.
- Back-to-back: assert start in the first cycle busy=0 → second frame begins next cycle; cs_n high gap ≥ CLK_DIV cycles between frames.
- Reset mid-frame: drop rst_n after 17 SCK rising edges → outputs at reset values immediately, no done pulse. A new transaction afterwards is bit-exact.
- CLK_DIV=1 build: read with addr=6'h01 and slave data 32'h00000001 → rdata=32'h1, cs_n low 81 cycles.
